rst_pulse_gen: RTL and testbench

Synthesizable reset-pulse generator: the design-side counterpart of the testbench reset-request interface. It accepts a reset request carrying a duration, drives the active-low `rst_n_out` line to the 6-bit ALU for exactly that many cycles, holds off for a recovery window, then reports completion. It sits between the stimulus/control logic and the ALU's `rst_n` input, and also provides the ALU's power-on reset after its own reset.

---
 rtl/rst_gen_pkg.sv | 14 +
 rtl/rst_gen_cnt.sv | 35 +++
 rtl/rst_pulse_gen.sv | 123 ++++++++++++
 tb/tb_rst_pulse_gen.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rst_gen_pkg.sv
// Shared types and defaults for the reset-pulse generator.
package rst_gen_pkg;

  typedef enum logic [1:0] {INIT, IDLE, ASSERT, RECOVER} rst_gen_state_e;

  localparam int unsigned POR_CYCLES_DEF = 4;
  localparam int unsigned POST_HOLD_DEF  = 2;

  // A zero-length request still produces a one-cycle pulse.
  function automatic int unsigned clamp_dur(input int unsigned dur);
    return (dur == 0) ? 1 : dur;
  endfunction

endpackage

// File: rtl/rst_gen_cnt.sv
// Loadable down counter shared by the power-on, assert and recovery phases.
module rst_gen_cnt #(
  parameter int unsigned W       = 8,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= W'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/rst_pulse_gen.sv
// Reset-pulse generator: power-on reset, then requested low pulses on rst_n_out with a
// recovery window and a completion pulse. All outputs come straight from flops.
module rst_pulse_gen
  import rst_gen_pkg::*;
#(
  parameter int unsigned DUR_W      = 8,
  parameter int unsigned POR_CYCLES = POR_CYCLES_DEF,
  parameter int unsigned POST_HOLD  = POST_HOLD_DEF,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [DUR_W-1:0] req_duration,
  output logic             req_ready,
  input  logic             req_abort,
  output logic             rst_n_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] reset_count
);

  localparam int unsigned CW = (DUR_W > 8) ? DUR_W : 8;

  rst_gen_state_e   state_q, state_d;
  logic             rst_n_out_q, rst_n_out_d;
  logic             req_ready_q, req_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] reset_count_q, reset_count_d;

  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0]    cnt_load_val;
  logic [CW-1:0]    dur_load_val;
  logic [CW-1:0]    hold_load_val;
  logic             accept;

  assign accept        = req_valid && req_ready_q;
  assign dur_load_val  = CW'(clamp_dur(32'(req_duration)) - 1);
  assign hold_load_val = CW'(POST_HOLD - 1);

  rst_gen_cnt #(
    .W       (CW),
    .RST_VAL (POR_CYCLES - 1)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = hold_load_val;
    done_d       = 1'b0;

    unique case (state_q)
      INIT: begin
        if (cnt_zero) state_d = IDLE;
        else          cnt_dec = 1'b1;
      end
      IDLE: begin
        if (accept) begin
          state_d      = ASSERT;
          cnt_load     = 1'b1;
          cnt_load_val = dur_load_val;
        end
      end
      ASSERT: begin
        if (cnt_zero || req_abort) begin
          state_d  = RECOVER;
          cnt_load = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RECOVER: begin
        if (cnt_zero) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = INIT;
    endcase

    // Outputs are decoded from the next state so they land in the same flop stage.
    rst_n_out_d   = (state_d == IDLE) || (state_d == RECOVER);
    req_ready_d   = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
    reset_count_d = done_d ? reset_count_q + CNT_W'(1) : reset_count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= INIT;
      rst_n_out_q   <= 1'b0;
      req_ready_q   <= 1'b0;
      busy_q        <= 1'b1;
      done_q        <= 1'b0;
      reset_count_q <= '0;
    end else begin
      state_q       <= state_d;
      rst_n_out_q   <= rst_n_out_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      reset_count_q <= reset_count_d;
    end
  end

  assign rst_n_out   = rst_n_out_q;
  assign req_ready   = req_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign reset_count = reset_count_q;

endmodule

// File: tb/tb_rst_pulse_gen.sv
// Directed bench for rst_pulse_gen: expected pulses are queued at request time and
// checked against the measured rst_n_out/done waveform.
module tb_rst_pulse_gen;

  localparam int unsigned DUR_W = 8;
  localparam int unsigned POR   = 4;
  localparam int unsigned HOLD  = 2;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic [DUR_W-1:0] req_duration = '0;
  logic             req_abort = 1'b0;
  logic             req_ready, rst_n_out, busy, done;
  logic [CNT_W-1:0] reset_count;

  typedef struct {
    int low;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_count = 0;

  always #5 clk = ~clk;

  rst_pulse_gen #(
    .DUR_W      (DUR_W),
    .POR_CYCLES (POR),
    .POST_HOLD  (HOLD),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_duration (req_duration),
    .req_ready    (req_ready),
    .req_abort    (req_abort),
    .rst_n_out    (rst_n_out),
    .busy         (busy),
    .done         (done),
    .reset_count  (reset_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " rst_n_out"}, 32'(rst_n_out), 0);
    chk({tag, " req_ready"}, 32'(req_ready), 0);
    chk({tag, " busy"}, 32'(busy), 1);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " reset_count"}, 32'(reset_count), 0);
  endtask

  // Entered with rst high; holds it 3 cycles, releases it and times the power-on pulse.
  task automatic check_por(input string tag);
    int low;
    int saw_done;
    repeat (3) @(negedge clk);
    chk_reset_vals({tag, " held"});
    rst = 1'b0;
    low = 0;
    saw_done = 0;
    while (rst_n_out === 1'b0 && low < 100) begin
      @(negedge clk);
      low++;
      if (done === 1'b1) saw_done = 1;
    end
    chk({tag, " low_cycles"}, 32'(low), POR);
    chk({tag, " req_ready"}, 32'(req_ready), 1);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done_seen"}, 32'(saw_done), 0);
    chk({tag, " reset_count"}, 32'(reset_count), 0);
  endtask

  // Called at a negedge in IDLE; returns at the negedge just after the accept edge.
  task automatic request(input int dur);
    exp_t e;
    req_valid    = 1'b1;
    req_duration = DUR_W'(dur);
    exp_count++;
    e.low = (dur == 0) ? 1 : dur;
    e.cnt = exp_count;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // From the release of rst_n_out: recovery length, done pulse, counter and ready.
  task automatic check_tail(input string tag, input int cnt);
    int hold;
    hold = 0;
    while (done !== 1'b1 && hold < 1000) begin
      hold++;
      @(negedge clk);
    end
    chk({tag, " recover_cycles"}, 32'(hold), HOLD);
    chk({tag, " reset_count"}, 32'(reset_count), 32'(cnt));
    chk({tag, " req_ready"}, 32'(req_ready), 1);
    chk({tag, " rst_n_out_high"}, 32'(rst_n_out), 1);
  endtask

  task automatic check_pulse(input string tag);
    exp_t e;
    int   n;
    int   low;
    chk({tag, " sb_nonempty"}, 32'(sb.size() != 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    n = 0;
    while (rst_n_out !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " started"}, 32'(n < 50), 1);
    low = 0;
    while (rst_n_out === 1'b0 && low < 1000) begin
      low++;
      @(negedge clk);
    end
    chk({tag, " low_cycles"}, 32'(low), 32'(e.low));
    check_tail(tag, e.cnt);
  endtask

  initial begin
    exp_t e;
    int   low;

    // Reset is asserted from time zero.
    check_por("por");

    request(5);
    check_pulse("basic");
    @(negedge clk);
    chk("basic done_one_cycle", 32'(done), 0);

    request(0);
    check_pulse("dur0");
    request(255);
    check_pulse("dur255");

    // Abort while idle must not disturb anything.
    req_abort = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_idle busy", 32'(busy), 0);
    chk("abort_idle rst_n_out", 32'(rst_n_out), 1);
    chk("abort_idle req_ready", 32'(req_ready), 1);
    req_abort = 1'b0;

    // Abort sampled on the 3rd ASSERT edge of a 20-cycle request.
    request(20);
    e = sb.pop_front();
    low = 0;
    for (int i = 0; i < 3; i++) begin
      if (rst_n_out === 1'b0) low++;
      if (i == 2) req_abort = 1'b1;
      @(negedge clk);
    end
    req_abort = 1'b0;
    chk("abort low_cycles", 32'(low), 3);
    chk("abort released", 32'(rst_n_out), 1);
    check_tail("abort", e.cnt);

    // Duration changed mid-pulse must be ignored.
    request(6);
    req_duration = 8'd200;
    check_pulse("dur_change");

    // Valid held high: three back-to-back pulses, later requests ignored while busy.
    req_valid    = 1'b1;
    req_duration = 8'd3;
    for (int i = 0; i < 3; i++) begin
      exp_count++;
      e.low = 3;
      e.cnt = exp_count;
      sb.push_back(e);
    end
    for (int i = 0; i < 3; i++) begin
      check_pulse($sformatf("b2b%0d", i));
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b idle_after", 32'(busy), 0);

    // Reset during cycle 2 of a 10-cycle pulse.
    request(10);
    @(negedge clk);
    chk("mid_rst pulse_active", 32'(rst_n_out), 0);
    rst = 1'b1;
    #1;
    chk_reset_vals("mid_rst async");
    sb.delete();
    exp_count = 0;
    check_por("por2");

    request(2);
    check_pulse("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop in case a wait is ever left unbounded.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
